// File: rtl/cpu_bus_sequencer_if.sv
// CPU bus sequencer port bundle: request channel, memory strobes, response and M-cycle status.
// master = sequencer side, slave = control unit / memory arbiter side.
interface cpu_bus_sequencer_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_wait;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_is_opcode;
  logic              rsp_is_cb;
  logic              rsp_err;
  logic              m_tick;
  logic              busy;

  modport master (
    input  req_valid, req_op, req_addr, req_wdata, mem_rdata, mem_wait,
    output req_ready, mem_addr, mem_wdata, mem_rd, mem_wr,
           rsp_valid, rsp_data, rsp_is_opcode, rsp_is_cb, rsp_err, m_tick, busy
  );

  modport slave (
    output req_valid, req_op, req_addr, req_wdata, mem_rdata, mem_wait,
    input  req_ready, mem_addr, mem_wdata, mem_rd, mem_wr,
           rsp_valid, rsp_data, rsp_is_opcode, rsp_is_cb, rsp_err, m_tick, busy
  );
endinterface

// File: rtl/cpu_bus_sequencer.sv
// One CPU bus op per T_PER_M-clock M-cycle: strobes T1..T_PER_M-2, response on the last T.
// mem_wait at the sample T stretches the M-cycle; CPU_BUS_WAIT_TIMEOUT_EN bounds it at MAX_WAIT.
module cpu_bus_sequencer #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int T_PER_M  = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  cpu_bus_sequencer_if.master bus
);
  localparam int TW = $clog2(T_PER_M);
  localparam logic [TW-1:0] T_LAST = TW'(T_PER_M - 1);
  localparam logic [TW-1:0] T_SAMP = TW'(T_PER_M - 2);

  localparam logic [2:0] OP_IDLE  = 3'd0;
  localparam logic [2:0] OP_IF    = 3'd1;
  localparam logic [2:0] OP_WRITE = 3'd2;
  localparam logic [2:0] OP_READ  = 3'd3;
  localparam logic [2:0] OP_IF_CB = 3'd4;

  if (T_PER_M < 3 || MAX_WAIT < 1) begin : g_param_check
    $error("cpu_bus_sequencer: T_PER_M must be >= 3 and MAX_WAIT >= 1");
  end

  logic [TW-1:0] t_cnt;
  logic [2:0]    cur_op;
  logic [2:0]    next_op;
  logic          is_rd;
  logic          is_wr;
  logic          at_samp;
  logic          at_last;
  logic          stall;
  logic          timeout;
  logic          accept;

  // cur_op only ever holds a legal opcode; 5-7 are folded to IDLE at capture
  assign is_rd   = (cur_op == OP_IF) || (cur_op == OP_READ) || (cur_op == OP_IF_CB);
  assign is_wr   = (cur_op == OP_WRITE);
  assign at_samp = (t_cnt == T_SAMP);
  assign at_last = (t_cnt == T_LAST);

`ifdef CPU_BUS_WAIT_TIMEOUT_EN
  localparam int WW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  logic [WW-1:0] wait_cnt;
  logic          err_q;

  assign timeout = at_samp & (is_rd | is_wr) & bus.mem_wait & (wait_cnt == WW'(MAX_WAIT));
  assign stall   = at_samp & (is_rd | is_wr) & bus.mem_wait & ~timeout;

  always_ff @(posedge clk) begin
    if (!rst_n || accept) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (stall)   wait_cnt <= wait_cnt + WW'(1);
      if (timeout) err_q    <= 1'b1;
    end
  end

  assign bus.rsp_err = at_last & err_q & rst_n;
`else
  assign timeout     = 1'b0;
  assign stall       = at_samp & (is_rd | is_wr) & bus.mem_wait;
  assign bus.rsp_err = 1'b0;
`endif

  assign accept        = at_last & ~stall & rst_n;
  assign bus.req_ready = accept;
  assign bus.m_tick    = accept;

  always_comb begin
    next_op = OP_IDLE;
    if (bus.req_valid && (bus.req_op <= OP_IF_CB)) next_op = bus.req_op;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      t_cnt         <= T_LAST;
      cur_op        <= OP_IDLE;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.rsp_data  <= '0;
    end else begin
      if (!stall) t_cnt <= at_last ? '0 : t_cnt + TW'(1);
      // address/data only move for real accesses so IDLE M-cycles keep the bus quiet
      if (accept) begin
        cur_op <= next_op;
        if (next_op != OP_IDLE)  bus.mem_addr  <= bus.req_addr;
        if (next_op == OP_WRITE) bus.mem_wdata <= bus.req_wdata;
      end
      if (at_samp && is_rd && !stall) bus.rsp_data <= timeout ? '1 : bus.mem_rdata;
    end
  end

  assign bus.mem_rd        = is_rd & (t_cnt != '0) & ~at_last;
  assign bus.mem_wr        = is_wr & (t_cnt != '0) & ~at_last;
  assign bus.rsp_valid     = at_last & is_rd & rst_n;
  assign bus.rsp_is_opcode = bus.rsp_valid & (cur_op == OP_IF);
  assign bus.rsp_is_cb     = bus.rsp_valid & (cur_op == OP_IF_CB);
  assign bus.busy          = (cur_op != OP_IDLE);
endmodule

// File: tb/tb_cpu_bus_sequencer.sv
// Bench for cpu_bus_sequencer: directed and random M-cycles against a per-M-cycle timeline model.
module tb_cpu_bus_sequencer;
  localparam int TPM  = 4;
  localparam int S    = TPM - 2;
  localparam int MAXW = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_bus_sequencer_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  cpu_bus_sequencer #(.ADDR_W(16), .DATA_W(8), .T_PER_M(TPM), .MAX_WAIT(MAXW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  int          mcyc     = 0;
  logic [2:0]  pend_op  = 3'd0;
  logic [15:0] exp_addr = '0;
  logic [7:0]  exp_wdata = '0;
  logic [7:0]  exp_rsp  = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s (mcycle %0d): observed %0h expected %0h", tag, mcyc, obs, exp);
    end
  endtask

  task automatic rand_req();
    bus.req_valid = 1'($urandom);
    bus.req_op    = 3'($urandom);
    bus.req_addr  = 16'($urandom);
    bus.req_wdata = 8'($urandom);
  endtask

  // Caller has already driven rst_n low; n reset edges, then the first released clock.
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rand_req();
      bus.mem_wait  = 1'($urandom);
      bus.mem_rdata = 8'($urandom);
      @(negedge clk);
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_m_tick", bus.m_tick, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_mem_rd", bus.mem_rd, 0);
      chk("rst_mem_wr", bus.mem_wr, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_data", bus.rsp_data, 0);
      chk("rst_rsp_is_opcode", bus.rsp_is_opcode, 0);
      chk("rst_rsp_is_cb", bus.rsp_is_cb, 0);
      chk("rst_rsp_err", bus.rsp_err, 0);
      chk("rst_busy", bus.busy, 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    rand_req();
    bus.req_valid = 1'b0;
    bus.mem_wait  = 1'($urandom);
    @(negedge clk);
    chk("rel_req_ready", bus.req_ready, 1);
    chk("rel_m_tick", bus.m_tick, 1);
    chk("rel_busy", bus.busy, 0);
    chk("rel_rsp_valid", bus.rsp_valid, 0);
    pend_op   = 3'd0;
    exp_addr  = '0;
    exp_wdata = '0;
    exp_rsp   = '0;
  endtask

  // Runs the M-cycle of pend_op with w wait clocks at the sample T and
  // presents (nv, nop, naddr, nwd) on its last clock. rv >= 0 forces the sampled read data.
  task automatic run_m(input int w, input int rv, input logic nv, input logic [2:0] nop,
                       input logic [15:0] naddr, input logic [7:0] nwd);
    logic [2:0] op;
    logic [7:0] cap;
    bit rd, wr, act, to, last;
    int ws, len, tpos;
    op  = (pend_op <= 3'd4) ? pend_op : 3'd0;
    rd  = (op == 3'd1) || (op == 3'd3) || (op == 3'd4);
    wr  = (op == 3'd2);
    act = rd || wr;
    ws  = act ? w : 0;
    to  = 1'b0;
`ifdef CPU_BUS_WAIT_TIMEOUT_EN
    if (ws > MAXW) begin
      ws = MAXW;
      to = 1'b1;
    end
`endif
    len = TPM + ws;
    cap = exp_rsp;
    for (int k = 0; k < len; k++) begin
      @(posedge clk); #1;
      tpos = (k < S) ? k : ((k <= S + ws) ? S : k - ws);
      last = (k == len - 1);
      bus.mem_rdata = 8'($urandom);
      if (tpos == S && k == S + ws && rv >= 0) bus.mem_rdata = rv[7:0];
      if (tpos == S) bus.mem_wait = act && (k < S + w);
      else           bus.mem_wait = 1'($urandom);
      if (last) begin
        bus.req_valid = nv;
        bus.req_op    = nop;
        bus.req_addr  = naddr;
        bus.req_wdata = nwd;
      end else begin
        rand_req();
      end
      if (rd && tpos == S && k == S + ws) cap = to ? 8'hFF : bus.mem_rdata;
      @(negedge clk);
      chk("busy", bus.busy, op != 3'd0);
      chk("mem_rd", bus.mem_rd, rd && tpos >= 1 && tpos <= S);
      chk("mem_wr", bus.mem_wr, wr && tpos >= 1 && tpos <= S);
      chk("mem_addr", bus.mem_addr, exp_addr);
      chk("mem_wdata", bus.mem_wdata, exp_wdata);
      chk("req_ready", bus.req_ready, last);
      chk("m_tick", bus.m_tick, last);
      chk("rsp_valid", bus.rsp_valid, rd && last);
      chk("rsp_is_opcode", bus.rsp_is_opcode, rd && last && op == 3'd1);
      chk("rsp_is_cb", bus.rsp_is_cb, rd && last && op == 3'd4);
      chk("rsp_err", bus.rsp_err, last && to);
      chk("rsp_data", bus.rsp_data, (rd && k > S + ws) ? cap : exp_rsp);
    end
    if (rd) exp_rsp = cap;
    pend_op = nv ? nop : 3'd0;
    if (nv && nop >= 3'd1 && nop <= 3'd4) exp_addr = naddr;
    if (nv && nop == 3'd2) exp_wdata = nwd;
    mcyc++;
  endtask

  initial begin
    logic [2:0]  r_op;
    logic        r_v;
    logic [15:0] r_a;
    logic [7:0]  r_d;
    int          r_w;

    bus.req_valid = 1'b0;
    bus.req_op    = 3'd0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.mem_rdata = '0;
    bus.mem_wait  = 1'b0;

    do_reset(3);
    run_m(0, -1,    1'b1, 3'd1, 16'h0100, 8'h00);  // IDLE, request IF
    run_m(0, 'h3E,  1'b1, 3'd2, 16'hC000, 8'hA5);  // IF 0x0100 -> 0x3E
    run_m(0, -1,    1'b1, 3'd3, 16'hC000, 8'h00);  // WRITE, back-to-back READ
    run_m(0, -1,    1'b1, 3'd3, 16'hFF44, 8'h00);  // READ 0xC000
    run_m(3, -1,    1'b1, 3'd4, 16'h0200, 8'h00);  // READ 0xFF44, 3 wait clocks
    run_m(0, -1,    1'b0, 3'd1, 16'h1111, 8'h11);  // IF_CB, then no request
    run_m(0, -1,    1'b1, 3'd6, 16'h2222, 8'h22);  // IDLE, request illegal op 6
    run_m(0, -1,    1'b1, 3'd3, 16'hABCD, 8'h00);  // illegal op cycle
    run_m(20, -1,   1'b1, 3'd2, 16'h5555, 8'h5A);  // READ with stuck wait
    run_m(20, -1,   1'b1, 3'd1, 16'h0042, 8'h00);  // WRITE with stuck wait

    for (int i = 0; i < 40; i++) begin
      r_op = 3'($urandom);
      r_v  = ($urandom_range(0, 3) != 0);
      r_a  = 16'($urandom);
      r_d  = 8'($urandom);
      r_w  = $urandom_range(0, 3);
      run_m(r_w, -1, r_v, r_op, r_a, r_d);
    end
    run_m(0, -1, 1'b1, 3'd3, 16'h1234, 8'h00);

    // READ 0x1234 stalled at the sample T, then reset lands mid-stall
    for (int k = 0; k <= S + 2; k++) begin
      @(posedge clk); #1;
      rand_req();
      bus.mem_rdata = 8'($urandom);
      bus.mem_wait  = (k >= S) ? 1'b1 : 1'($urandom);
      if (k == S + 2) rst_n = 1'b0;
      @(negedge clk);
      chk("abort_rsp_valid", bus.rsp_valid, 0);
      chk("abort_m_tick", bus.m_tick, 0);
      if (k < S + 2) chk("abort_mem_rd", bus.mem_rd, k >= 1);
    end
    do_reset(3);
    run_m(0, -1,   1'b1, 3'd1, 16'h0040, 8'h00);
    run_m(0, 'h77, 1'b0, 3'd0, 16'h0000, 8'h00);
    run_m(0, -1,   1'b0, 3'd0, 16'h0000, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
